// File: rtl/alu_pkg.sv
// Shared types and 7-segment glyphs for the multi-cycle ALU.
// Modes 1000/1001 are valid only when ALU_DIV_EN is defined.
package alu_pkg;

  typedef enum logic [3:0] {
    MODE_ADD = 4'b0000,
    MODE_SUB = 4'b0001,
    MODE_MUL = 4'b0010,
    MODE_AND = 4'b0011,
    MODE_OR  = 4'b0100,
    MODE_XOR = 4'b0101,
    MODE_SHL = 4'b0110,
    MODE_SHR = 4'b0111,
    MODE_QUO = 4'b1000,
    MODE_REM = 4'b1001
  } alu_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DIV
  } alu_state_e;

  // Active-low glyphs, bit order gfedcba.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_ERR   = 7'b0001001;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] mode_glyph(input logic [3:0] m);
    case (m)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_ERR;
    endcase
  endfunction

endpackage

// File: rtl/alu_multiciclo_if.sv
// Operand/result bundle between the ALU and its requester.
interface alu_multiciclo_if #(parameter int N = 4);
  logic           start;
  logic [N-1:0]   in1;
  logic [N-1:0]   in2;
  logic [3:0]     mode;
  logic           busy;
  logic           done;
  logic [2*N-1:0] result;
  logic           neg;
  logic           cero;
  logic           carry;
  logic           err;
  logic [6:0]     mode_seg;

  modport master (output start, in1, in2, mode,
                  input  busy, done, result, neg, cero, carry, err, mode_seg);
  modport slave  (input  start, in1, in2, mode,
                  output busy, done, result, neg, cero, carry, err, mode_seg);
endinterface

// File: rtl/divisor_nbits.sv
// Iterative restoring divider: quotient and remainder of N-bit unsigned
// operands in N cycles; done_o is high for one cycle once both are valid.
module divisor_nbits #(parameter int N = 4) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [N-1:0] dividend_i,
  input  logic [N-1:0] divisor_i,
  output logic         done_o,
  output logic [N-1:0] quotient_o,
  output logic [N-1:0] remainder_o
);
  localparam int CW = $clog2(N + 1);

  logic [CW-1:0] cnt_q;
  logic          act_q;
  logic [N-1:0]  rem_q, quo_q, dvs_q;
  logic [N:0]    rem_shift, trial;

  assign rem_shift = {rem_q, quo_q[N-1]};
  assign trial     = rem_shift - {1'b0, dvs_q};

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      act_q <= 1'b0;
      cnt_q <= '0;
    end else if (start_i) begin
      act_q <= 1'b1;
      cnt_q <= CW'(N);
    end else if (act_q) begin
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      else             act_q <= 1'b0;
    end
  end

  // NOTE: datapath registers carry no reset; act_q qualifies their contents.
  always_ff @(posedge clk) begin
    if (start_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
    end else if (act_q && cnt_q != '0) begin
      rem_q <= trial[N] ? rem_shift[N-1:0] : trial[N-1:0];
      quo_q <= {quo_q[N-2:0], ~trial[N]};
    end
  end

  assign done_o      = act_q && (cnt_q == '0);
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
endmodule

// File: rtl/alu_multiciclo.sv
// Multi-cycle N-bit ALU with registered result/flags and mode glyph.
// Define ALU_DIV_EN to enable quotient/remainder via divisor_nbits.
module alu_multiciclo
  import alu_pkg::*;
#(parameter int N = 4) (
  input logic clk,
  input logic rst,
  alu_multiciclo_if.slave bus
);
  localparam logic [N:0] SHL_LIM = (N+1)'(2 * N);

  alu_state_e     state_q, state_d;
  logic [N-1:0]   a_q, b_q;
  logic [3:0]     mode_q;
  logic [2*N-1:0] result_q, res_d;
  logic           neg_q, carry_q, cero_q, err_q, done_q;
  logic           neg_d, carry_d, cero_d, err_d, valid;
  logic [6:0]     seg_q;
  logic           load, upd, div_start, div_done;

  logic [N:0]     sum_w;
  logic [2*N-1:0] prod_w;
  logic [N-1:0]   diff_w;

  assign sum_w  = {1'b0, a_q} + {1'b0, b_q};
  assign prod_w = {{N{1'b0}}, a_q} * {{N{1'b0}}, b_q};
  assign diff_w = (a_q < b_q) ? (b_q - a_q) : (a_q - b_q);

`ifdef ALU_DIV_EN
  logic [N-1:0] div_quo, div_rem;

  divisor_nbits #(.N(N)) u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (div_start),
    .dividend_i  (bus.in1),
    .divisor_i   (bus.in2),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );
`else
  assign div_done = 1'b0;
`endif

  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    state_d   = state_q;
    load      = 1'b0;
    upd       = 1'b0;
    div_start = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.start) begin
        load    = 1'b1;
        state_d = ST_EXEC;
`ifdef ALU_DIV_EN
        if ((bus.mode == MODE_QUO || bus.mode == MODE_REM) && bus.in2 != '0) begin
          div_start = 1'b1;
          state_d   = ST_DIV;
        end
`endif
      end
      ST_EXEC: begin
        upd     = 1'b1;
        state_d = ST_IDLE;
      end
      ST_DIV: if (div_done) begin
        upd     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    res_d   = '0;
    neg_d   = 1'b0;
    carry_d = 1'b0;
    err_d   = 1'b0;
    valid   = 1'b1;
    case (mode_q)
      MODE_ADD: begin
        res_d   = {{(N-1){1'b0}}, sum_w};
        carry_d = sum_w[N];
      end
      MODE_SUB: begin
        res_d = {{N{1'b0}}, diff_w};
        neg_d = (a_q < b_q);
      end
      MODE_MUL: begin
        res_d   = prod_w;
        carry_d = |prod_w[2*N-1:N];
      end
      MODE_AND: res_d = {{N{1'b0}}, a_q & b_q};
      MODE_OR:  res_d = {{N{1'b0}}, a_q | b_q};
      MODE_XOR: res_d = {{N{1'b0}}, a_q ^ b_q};
      MODE_SHL: res_d = ({1'b0, b_q} >= SHL_LIM) ? '0 : ({{N{1'b0}}, a_q} << b_q);
      MODE_SHR: res_d = {{N{1'b0}}, a_q >> b_q};
`ifdef ALU_DIV_EN
      // A zero divisor never reaches the divider; it is resolved here in EXEC.
      MODE_QUO: begin
        res_d = {{N{1'b0}}, (b_q == '0) ? {N{1'b1}} : div_quo};
        err_d = (b_q == '0);
      end
      MODE_REM: begin
        res_d = {{N{1'b0}}, (b_q == '0) ? a_q : div_rem};
        err_d = (b_q == '0);
      end
`endif
      default: begin
        err_d = 1'b1;
        valid = 1'b0;
      end
    endcase
    cero_d = valid && (res_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      cero_q   <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      seg_q    <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      done_q  <= upd;
      if (load) begin
        a_q    <= bus.in1;
        b_q    <= bus.in2;
        mode_q <= bus.mode;
      end
      if (upd) begin
        result_q <= res_d;
        neg_q    <= neg_d;
        carry_q  <= carry_d;
        cero_q   <= cero_d;
        err_q    <= err_d;
        seg_q    <= valid ? mode_glyph(mode_q) : SEG_ERR;
      end
    end
  end

  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.neg      = neg_q;
  assign bus.carry    = carry_q;
  assign bus.cero     = cero_q;
  assign bus.err      = err_q;
  assign bus.mode_seg = seg_q;
endmodule

// File: doc/alu_multiciclo.md
# alu_multiciclo

Parametrised, clocked successor to the lab's combinational N-bit ALU. Operands and operation code are captured on a `start` handshake. Single-cycle operations complete in one execute cycle. Division and modulo run on an iterative restoring divider. Results and flags are held in registers until the next operation completes, so the board-level display and LED logic see stable values.

## Interface
Parameters:
- `N`, default 4: operand width in bits; legal range 2 to 16.

Ports:
- `clk`  in  1  single system clock; all state changes on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `in1`  in  N  operand A, unsigned
- `in2`  in  N  operand B, unsigned
- `mode`  in  4  operation code, latched with `start`
- `busy`  out  1  high while an operation is in flight
- `done`  out  1  one-cycle pulse when results update
- `result`  out  2N  registered result
- `neg`  out  1  subtraction was negative
- `cero`  out  1  `result` equals zero
- `carry`  out  1  add carry-out, or multiply overflow past N bits
- `err`  out  1  invalid mode or divide by zero
- `mode_seg`  out  7  active-low 7-segment glyph of the latched mode

## Operation
- States:
  - IDLE: `start` latches `in1`, `in2` and `mode`.
    - Goes to DIV when mode is 1000 or 1001 and `in2` ≠ 0.
    - Goes to EXEC for every other mode.
  - EXEC: computes and registers the result, pulses `done`, returns to IDLE.
  - DIV: iterates N times, then registers the result, pulses `done`, returns to IDLE.
- Mode encoding:
  - 0000 add: `result` = {carry, A+B}, zero-extended.
  - 0001 subtract: `result` = |A−B|; `neg` = (A<B).
  - 0010 multiply: full 2N-bit product; `carry` = 1 if upper N bits are nonzero.
  - 0011 AND, 0100 OR, 0101 XOR: N-bit result, zero-extended.
  - 0110 shift left: result = zero-extended A shifted left by B, 2N bits wide, no truncation. B ≥ 2N gives 0.
  - 0111 shift right: A shifted right by B (logical).
  - 1000 quotient, 1001 remainder.
  - 1010–1111: `err`=1, `result`=0, `cero`=0.
- Flags:
  - `neg` and `carry` are 0 except for the operations listed above.
  - `cero` = (`result` == 0), except in the invalid-mode case.
  - `mode_seg` shows digits 0–9 for valid modes and "H" (0001001) for invalid modes.
- Divide by zero (mode 1000/1001 with B=0): goes through EXEC, not DIV. Quotient = all ones, remainder = A, `err`=1.
- `start` while `busy` is ignored; the new operands are not queued.
- Outputs hold their last values until the next `done`.

## Timing
- Reset values: all outputs 0, `mode_seg` = 1111111, state IDLE.
- `start` sampled at rising edge k:
  - `busy` is high from edge k onward.
  - Non-divide operations: `result`, flags and `done` update at edge k+1. Latency is 1 cycle after capture.
  - Divide and modulo: update at edge k+N+1.
  - `busy` falls on the same edge that raises `done`.
- Back-to-back: `start` held high re-captures at the edge after `done`. Maximum issue rate is one operation per 2 cycles.
- Reset asserted mid-operation: the operation aborts immediately, outputs go to reset values, and no `done` is issued.

## Configuration
- Macro `ALU_DIV_EN`:
  - Defined: the divider is instantiated and modes 1000/1001 behave as specified above.
  - Undefined: the divider and DIV state are removed. Modes 1000/1001 take the invalid-mode path (`err`=1, `result`=0, "H" glyph) with EXEC latency.

## Structure
- `alu_pkg` holds:
  - `alu_mode_e`: 4-bit enum of the operation codes.
  - `alu_state_e`: IDLE/EXEC/DIV.
  - The 7-segment glyph constants for modes 0–9 and the error glyph.
- Sub-module `divisor_nbits`, parameter `N`:
  - Iterative restoring divider with start/done.
  - Produces the quotient and remainder, each N bits, in N cycles.
  - Instantiated only under `ALU_DIV_EN`.

## Test plan
Directed scenarios at N=4:
- Add A=9, B=8 → `result`=0x11 (17), `carry`=1, `cero`=0, `done` at edge k+1.
- Subtract A=3, B=7 → `result`=4, `neg`=1. Subtract A=5, B=5 → `result`=0, `cero`=1.
- Multiply A=15, B=15 → `result`=225, `carry`=1. Shift left A=15, B=3 → `result`=120.
- Divide A=13, B=4 (`ALU_DIV_EN` defined):
  - Quotient `result`=3, `done` at edge k+5.
  - Repeated with modulo: `result`=1.
  - B=0 → `result`=15, `err`=1, `done` at edge k+1.
- Mode 1100 → `err`=1, `result`=0, `cero`=0, `mode_seg`=0001001. Without `ALU_DIV_EN`, mode 1000 gives the same response.
- Handshake and reset:
  - `start` pulsed during a divide → ignored.
  - `rst` asserted mid-divide → all outputs 0, `done` never pulses.
  - After release, a new add completes normally.
